// File: rtl/pkg_controle.sv
// Shared definitions for the multicycle control unit: FSM states, the 3-bit opcode map,
// ULA operation codes and PC source selects.
package pkg_controle;

  typedef enum logic [2:0] {
    OCIOSO,
    BUSCA,
    DECOD,
    EXEC,
    MEM,
    ESCRITA,
    PARADO,
    ERRO
  } estado_t;

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_LW   = 3'b001;
  localparam logic [2:0] OP_SW   = 3'b010;
  localparam logic [2:0] OP_BEQZ = 3'b011;
  localparam logic [2:0] OP_ADDI = 3'b100;
  localparam logic [2:0] OP_J    = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [1:0] ULA_ADD   = 2'b00;
  localparam logic [1:0] ULA_SUB   = 2'b01;
  localparam logic [1:0] ULA_FUNCT = 2'b10;
  localparam logic [1:0] ULA_ADDI  = 2'b11;

  localparam logic [1:0] PC_MAIS1  = 2'b00;
  localparam logic [1:0] PC_DESVIO = 2'b01;
  localparam logic [1:0] PC_SALTO  = 2'b10;

  // R-type and SUB write the rd field; LW and ADDI write the rt field.
  function automatic logic usa_rd(input logic [2:0] op);
    return (op == OP_R) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/contador_espera.sv
// Memory wait counter with timeout detection.
// Ports:
//   clock     - system clock, rising edge
//   reset_n   - asynchronous active-low reset
//   ativo_i   - FSM is in a state waiting on memory
//   pronta_i  - memory completed the access this cycle
//   estouro_o - wait limit reached while memory is still not ready
module contador_espera #(
  parameter int unsigned ESPERA_MAX = 15
) (
  input  logic clock,
  input  logic reset_n,
  input  logic ativo_i,
  input  logic pronta_i,
  output logic estouro_o
);

  logic [7:0] espera_q, espera_d;

  // A ready memory in the same cycle takes priority over the timeout.
  assign estouro_o = ativo_i && !pronta_i && (espera_q == 8'(ESPERA_MAX));

  // Clearing whenever not actively waiting covers both ready and any state exit.
  always_comb begin
    espera_d = '0;
    if (ativo_i && !pronta_i && !estouro_o) begin
      espera_d = espera_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      espera_q <= '0;
    end else begin
      espera_q <= espera_d;
    end
  end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control unit: sequences fetch, decode, execute, memory and writeback for
// the 3-bit opcode set, with a memory-ready handshake, timeout error and halt state.
// Ports:
//   clock, reset_n       - clock (rising edge), asynchronous active-low reset
//   Iniciar              - start execution from OCIOSO
//   Opcode               - instruction register opcode field
//   Zero                 - ULA zero flag (BEQZ decision)
//   MemPronta            - memory completed the current access
//   EscIR .. FontePC     - datapath strobes and mux selects
//   Parado / Erro        - halted / memory timeout (both sticky until reset)
//   NumInstr             - retired instruction counter, wraps
module unidade_controle_multiciclo
  import pkg_controle::*;
#(
  parameter int unsigned ESPERA_MAX = 15,
  parameter int unsigned W_CONT     = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              Iniciar,
  input  logic [2:0]        Opcode,
  input  logic              Zero,
  input  logic              MemPronta,
  output logic              EscIR,
  output logic              IouD,
  output logic              LerMem,
  output logic              EscMem,
  output logic [1:0]        ULAOp,
  output logic              ULAFonte,
  output logic              SelDest,
  output logic              RegFonte,
  output logic              EscReg,
  output logic              EscPC,
  output logic [1:0]        FontePC,
  output logic              Parado,
  output logic              Erro,
  output logic [W_CONT-1:0] NumInstr
);

  estado_t             estado_q, estado_d;
  logic [2:0]          op_q, op_d;
  logic [W_CONT-1:0]   num_q, num_d;
  logic                retira;
  logic                esperando;
  logic                estouro;

  assign esperando = (estado_q == BUSCA) || (estado_q == MEM);

  contador_espera #(
    .ESPERA_MAX(ESPERA_MAX)
  ) u_contador_espera (
    .clock    (clock),
    .reset_n  (reset_n),
    .ativo_i  (esperando),
    .pronta_i (MemPronta),
    .estouro_o(estouro)
  );

  always_comb begin
    estado_d = estado_q;
    op_d     = op_q;
    retira   = 1'b0;
    EscIR    = 1'b0;
    IouD     = 1'b0;
    LerMem   = 1'b0;
    EscMem   = 1'b0;
    ULAOp    = ULA_ADD;
    ULAFonte = 1'b0;
    SelDest  = 1'b0;
    RegFonte = 1'b0;
    EscReg   = 1'b0;
    EscPC    = 1'b0;
    FontePC  = PC_MAIS1;
    Parado   = 1'b0;
    Erro     = 1'b0;

    unique case (estado_q)
      OCIOSO: begin
        if (Iniciar) estado_d = BUSCA;
      end
      BUSCA: begin
        LerMem = 1'b1;
        if (MemPronta) begin
          // IR load and PC+1 happen in the same cycle the fetch completes.
          EscIR    = 1'b1;
          EscPC    = 1'b1;
          FontePC  = PC_MAIS1;
          estado_d = DECOD;
        end else if (estouro) begin
          estado_d = ERRO;
        end
      end
      DECOD: begin
        op_d = Opcode;
        if (Opcode == OP_HALT) begin
          estado_d = PARADO;
          retira   = 1'b1;
        end else begin
          estado_d = EXEC;
        end
      end
      EXEC: begin
        case (op_q)
          OP_R: begin
            ULAOp    = ULA_FUNCT;
            estado_d = ESCRITA;
          end
          OP_SUB: begin
            ULAOp    = ULA_SUB;
            estado_d = ESCRITA;
          end
          OP_ADDI: begin
            ULAOp    = ULA_ADDI;
            ULAFonte = 1'b1;
            estado_d = ESCRITA;
          end
          OP_LW, OP_SW: begin
            ULAOp    = ULA_ADD;
            ULAFonte = 1'b1;
            estado_d = MEM;
          end
          OP_BEQZ: begin
            FontePC  = PC_DESVIO;
            EscPC    = Zero;
            estado_d = BUSCA;
            retira   = 1'b1;
          end
          OP_J: begin
            FontePC  = PC_SALTO;
            EscPC    = 1'b1;
            estado_d = BUSCA;
            retira   = 1'b1;
          end
          default: begin
            // HALT never reaches EXEC; recover by refetching.
            estado_d = BUSCA;
          end
        endcase
      end
      MEM: begin
        IouD = 1'b1;
        if (op_q == OP_SW) EscMem = 1'b1;
        else               LerMem = 1'b1;
        if (MemPronta) begin
          if (op_q == OP_SW) begin
            estado_d = BUSCA;
            retira   = 1'b1;
          end else begin
            estado_d = ESCRITA;
          end
        end else if (estouro) begin
          estado_d = ERRO;
        end
      end
      ESCRITA: begin
        EscReg   = 1'b1;
        RegFonte = (op_q == OP_LW);
        SelDest  = usa_rd(op_q);
        estado_d = BUSCA;
        retira   = 1'b1;
      end
      PARADO: begin
        Parado = 1'b1;
      end
      ERRO: begin
        Erro = 1'b1;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  always_comb begin
    num_d = num_q;
    if (retira) num_d = num_q + W_CONT'(1);
  end

  assign NumInstr = num_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= OCIOSO;
      op_q     <= '0;
      num_q    <= '0;
    end else begin
      estado_q <= estado_d;
      op_q     <= op_d;
      num_q    <= num_d;
    end
  end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Self-checking bench for the multicycle control unit: directed vector table, hand-written
// corner sequences and randomized instruction streams against a per-instruction model.
module tb_unidade_controle_multiciclo;

  localparam logic [2:0] OP_R = 3'b000, OP_LW = 3'b001, OP_SW = 3'b010, OP_BEQZ = 3'b011;
  localparam logic [2:0] OP_ADDI = 3'b100, OP_J = 3'b101, OP_SUB = 3'b110, OP_HALT = 3'b111;

  logic        clock, reset_n, Iniciar, Zero, MemPronta;
  logic [2:0]  Opcode;
  logic        EscIR, IouD, LerMem, EscMem, ULAFonte, SelDest, RegFonte, EscReg, EscPC;
  logic        Parado, Erro;
  logic [1:0]  ULAOp, FontePC;
  logic [15:0] NumInstr;
  logic [14:0] saidas;

  int n_cmp = 0;
  int n_err = 0;
  int modelo_num = 0;

  unidade_controle_multiciclo #(
    .ESPERA_MAX(15),
    .W_CONT    (16)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .Iniciar  (Iniciar),
    .Opcode   (Opcode),
    .Zero     (Zero),
    .MemPronta(MemPronta),
    .EscIR    (EscIR),
    .IouD     (IouD),
    .LerMem   (LerMem),
    .EscMem   (EscMem),
    .ULAOp    (ULAOp),
    .ULAFonte (ULAFonte),
    .SelDest  (SelDest),
    .RegFonte (RegFonte),
    .EscReg   (EscReg),
    .EscPC    (EscPC),
    .FontePC  (FontePC),
    .Parado   (Parado),
    .Erro     (Erro),
    .NumInstr (NumInstr)
  );

  assign saidas = {EscIR, IouD, LerMem, EscMem, ULAOp, ULAFonte, SelDest, RegFonte, EscReg,
                   EscPC, FontePC, Parado, Erro};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [14:0] mk(input logic escir, ioud, ler, escmem,
                                     input logic [1:0] ulaop, input logic ulaf, sel, regf,
                                     escreg, escpc, input logic [1:0] fpc,
                                     input logic par, err);
    return {escir, ioud, ler, escmem, ulaop, ulaf, sel, regf, escreg, escpc, fpc, par, err};
  endfunction

  // Expected outputs derived from what each phase must do to the datapath.
  function automatic logic [14:0] e_busca(input logic mp);
    return mk(mp, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, mp, 2'b00, 1'b0, 1'b0);
  endfunction

  function automatic logic [14:0] e_exec(input logic [2:0] op, input logic z);
    case (op)
      OP_R:    return mk(0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      OP_SUB:  return mk(0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      OP_ADDI: return mk(0, 0, 0, 0, 2'b11, 1, 0, 0, 0, 0, 2'b00, 0, 0);
      OP_LW:   return mk(0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 2'b00, 0, 0);
      OP_SW:   return mk(0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 2'b00, 0, 0);
      OP_BEQZ: return mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, z, 2'b01, 0, 0);
      OP_J:    return mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 2'b10, 0, 0);
      default: return '0;
    endcase
  endfunction

  function automatic logic [14:0] e_mem(input logic [2:0] op);
    if (op == OP_SW) return mk(0, 1, 0, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    return mk(0, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
  endfunction

  function automatic logic [14:0] e_escrita(input logic [2:0] op);
    logic rd;
    logic lw;
    rd = (op == OP_R) || (op == OP_SUB);
    lw = (op == OP_LW);
    return mk(0, 0, 0, 0, 2'b00, 0, rd, lw, 1, 0, 2'b00, 0, 0);
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] rop();
    return 3'($urandom_range(0, 7));
  endfunction

  function automatic int espera_aleatoria();
    if ($urandom_range(0, 15) == 0) return 15;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic checa(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    n_cmp++;
    if (atual !== esperado) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nome, atual, esperado, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, advance past the rising edge.
  task automatic passo(input logic ini, input logic [2:0] op, input logic z, input logic mp,
                       input logic [14:0] es, input string nome);
    Iniciar   = ini;
    Opcode    = op;
    Zero      = z;
    MemPronta = mp;
    @(negedge clock);
    checa({nome, " saidas"}, 32'(saidas), 32'(es));
    checa({nome, " NumInstr"}, 32'(NumInstr), 32'(16'(modelo_num)));
    @(posedge clock);
    #1;
  endtask

  // Whole instruction from fetch onward; inputs the controller must ignore are randomized.
  task automatic executa(input logic [2:0] op, input int wb, input int wm);
    logic z;
    for (int i = 0; i < wb; i++) passo(rb(), rop(), rb(), 1'b0, e_busca(1'b0), "busca espera");
    passo(rb(), rop(), rb(), 1'b1, e_busca(1'b1), "busca");
    passo(rb(), op, rb(), rb(), '0, "decod");
    if (op == OP_HALT) begin
      modelo_num++;
      return;
    end
    z = rb();
    passo(rb(), rop(), z, rb(), e_exec(op, z), "exec");
    if (op == OP_BEQZ || op == OP_J) begin
      modelo_num++;
      return;
    end
    if (op == OP_LW || op == OP_SW) begin
      for (int i = 0; i < wm; i++) passo(rb(), rop(), rb(), 1'b0, e_mem(op), "mem espera");
      passo(rb(), rop(), rb(), 1'b1, e_mem(op), "mem");
      if (op == OP_SW) begin
        modelo_num++;
        return;
      end
    end
    passo(rb(), rop(), rb(), rb(), e_escrita(op), "escrita");
    modelo_num++;
  endtask

  task automatic pulso_reset();
    #2;
    reset_n = 1'b0;
    #1;
    modelo_num = 0;
    checa("reset saidas", 32'(saidas), 32'd0);
    checa("reset NumInstr", 32'(NumInstr), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic        ini;
    logic [2:0]  op;
    logic        z;
    logic        mp;
    logic [14:0] saida;
    int          num;
  } vetor_t;

  vetor_t tab[12];

  initial begin
    Iniciar   = 1'b0;
    Opcode    = 3'b000;
    Zero      = 1'b0;
    MemPronta = 1'b0;
    reset_n   = 1'b1;
    #1;
    reset_n   = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    checa("reset inicial saidas", 32'(saidas), 32'd0);
    checa("reset inicial NumInstr", 32'(NumInstr), 32'd0);
    reset_n = 1'b1;

    // R-type with immediate memory, then BEQZ taken and not taken.
    tab[0]  = '{1'b1, OP_R,    1'b0, 1'b1, 15'd0,                   0};
    tab[1]  = '{1'b0, OP_HALT, 1'b0, 1'b1, e_busca(1'b1),           0};
    tab[2]  = '{1'b0, OP_R,    1'b0, 1'b1, 15'd0,                   0};
    tab[3]  = '{1'b0, OP_HALT, 1'b1, 1'b0, e_exec(OP_R, 1'b1),      0};
    tab[4]  = '{1'b0, OP_HALT, 1'b0, 1'b1, e_escrita(OP_R),         0};
    tab[5]  = '{1'b0, OP_R,    1'b0, 1'b0, e_busca(1'b0),           1};
    tab[6]  = '{1'b0, OP_R,    1'b0, 1'b1, e_busca(1'b1),           1};
    tab[7]  = '{1'b0, OP_BEQZ, 1'b0, 1'b1, 15'd0,                   1};
    tab[8]  = '{1'b0, OP_R,    1'b1, 1'b0, e_exec(OP_BEQZ, 1'b1),   1};
    tab[9]  = '{1'b0, OP_R,    1'b0, 1'b1, e_busca(1'b1),           2};
    tab[10] = '{1'b0, OP_BEQZ, 1'b1, 1'b1, 15'd0,                   2};
    tab[11] = '{1'b0, OP_R,    1'b0, 1'b0, e_exec(OP_BEQZ, 1'b0),   2};
    for (int i = 0; i < 12; i++) begin
      modelo_num = tab[i].num;
      passo(tab[i].ini, tab[i].op, tab[i].z, tab[i].mp, tab[i].saida, $sformatf("vetor %0d", i));
    end
    modelo_num = 3;

    // LW with memory ready after three wait cycles, then boundary waits of exactly 15.
    executa(OP_LW, 0, 3);
    executa(OP_ADDI, 15, 0);
    executa(OP_SW, 0, 15);
    executa(OP_LW, 15, 15);

    for (int k = 0; k < 150; k++) begin
      executa(3'($urandom_range(0, 6)), espera_aleatoria(), espera_aleatoria());
    end

    // HALT retires and then ignores everything.
    executa(OP_HALT, 0, 0);
    for (int i = 0; i < 20; i++) begin
      passo(rb(), rop(), rb(), rb(), mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 0), "parado");
    end

    pulso_reset();
    passo(1'b0, rop(), rb(), rb(), '0, "ocioso");
    passo(1'b0, rop(), rb(), rb(), '0, "ocioso");
    passo(1'b1, rop(), rb(), rb(), '0, "ocioso inicia");

    // Fetch never completes: sixteen waiting cycles, then a sticky error.
    for (int i = 0; i < 16; i++) passo(rb(), rop(), rb(), 1'b0, e_busca(1'b0), "busca timeout");
    for (int i = 0; i < 6; i++) begin
      passo(1'b1, rop(), rb(), rb(), mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 1), "erro");
    end

    // Reset arriving mid-store must drop the write strobe without waiting for a clock.
    pulso_reset();
    passo(1'b1, rop(), rb(), rb(), '0, "ocioso inicia");
    executa(OP_J, 0, 0);
    passo(1'b0, rop(), rb(), 1'b1, e_busca(1'b1), "sw busca");
    passo(1'b0, OP_SW, rb(), rb(), '0, "sw decod");
    passo(1'b0, rop(), rb(), rb(), e_exec(OP_SW, 1'b0), "sw exec");
    passo(1'b0, rop(), rb(), 1'b0, e_mem(OP_SW), "sw mem espera");
    checa("sw mem antes do reset", 32'(saidas), 32'(e_mem(OP_SW)));
    checa("NumInstr antes do reset", 32'(NumInstr), 32'd1);
    pulso_reset();
    passo(1'b0, rop(), rb(), rb(), '0, "ocioso apos reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/unidade_controle_multiciclo.md
Name: unidade_controle_multiciclo

Overview:
- Multicycle controller FSM that sequences the processor datapath (ULA, register file, instruction register, PC, unified memory) over several cycles per instruction.
- Same 3-bit opcode map and ULAOp encoding as the single-cycle control unit.
- Adds a memory ready handshake with timeout, a halt state and a retired-instruction counter.
- Sits between the instruction register and the datapath muxes and enables.

Parameters:
- ESPERA_MAX, 15: max consecutive wait cycles for MemPronta before ERRO; range 1..255.
- W_CONT, 16: width of the NumInstr counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- Iniciar  in  1  leaves OCIOSO.
- Opcode  in  3  IR[opcode]; valid from DECOD onward.
- Zero  in  1  ULA result-equals-zero flag.
- MemPronta  in  1  memory completed the current read/write this cycle.
- EscIR  out  1  load instruction register.
- IouD  out  1  memory address: 0=PC, 1=ULA result register.
- LerMem  out  1  memory read request.
- EscMem  out  1  memory write request.
- ULAOp  out  2  00 add, 01 sub, 10 funct-decode, 11 addi.
- ULAFonte  out  1  ULA B: 0=register, 1=immediate.
- SelDest  out  1  destination register field select.
- RegFonte  out  1  writeback data: 0=ULA, 1=memory data.
- EscReg  out  1  register file write.
- EscPC  out  1  PC write.
- FontePC  out  2  00 PC+1, 01 branch target, 10 jump target.
- Parado  out  1  halted.
- Erro  out  1  memory timeout; sticky.
- NumInstr  out  W_CONT  retired instructions.

Behaviour:
- Reset (async, immediate): state=OCIOSO, OpReg=0, EsperaCnt=0, NumInstr=0, Erro=0, and every output 0.
- Outputs are Moore-decoded from state and OpReg. The only exceptions are MemPronta-qualified strobes and BEQZ EscPC. All are 0 unless listed below.
- OCIOSO: Iniciar=1 -> BUSCA.
- BUSCA: IouD=0, LerMem=1.
  - On MemPronta: EscIR=1, EscPC=1, FontePC=00 (same cycle), then -> DECOD.
- DECOD: OpReg<=Opcode.
  - 111 -> PARADO; NumInstr+1.
  - Otherwise -> EXEC.
- EXEC, by OpReg:
  - 000: ULAOp=10, ULAFonte=0 -> ESCRITA.
  - 110: ULAOp=01, ULAFonte=0 -> ESCRITA.
  - 100: ULAOp=11, ULAFonte=1 -> ESCRITA.
  - 001/010: ULAOp=00, ULAFonte=1 -> MEM.
  - 011: ULAOp=00, FontePC=01, EscPC=Zero (combinational) -> BUSCA; retire.
  - 101: FontePC=10, EscPC=1 -> BUSCA; retire.
- MEM: IouD=1.
  - 001: LerMem=1; on MemPronta -> ESCRITA.
  - 010: EscMem=1; on MemPronta -> BUSCA; retire.
- ESCRITA: EscReg=1 -> BUSCA; retire.
  - RegFonte=1 only for 001.
  - SelDest=1 for 000/110; SelDest=0 for 001/100.
- Retire: NumInstr+1 on the transition out of the final state. The counter wraps mod 2^W_CONT.
- Memory wait (BUSCA and MEM):
  - EsperaCnt increments each cycle MemPronta=0.
  - EsperaCnt clears on MemPronta=1 and on any state exit.
  - If EsperaCnt==ESPERA_MAX with MemPronta=0 -> ERRO.
  - MemPronta=1 in the same cycle wins over the timeout.
- ERRO: Erro=1; all strobes 0; remains until reset.
- PARADO: Parado=1; all strobes 0; remains until reset; Iniciar is ignored.
- MemPronta outside BUSCA/MEM is ignored.
- Zero is sampled only in EXEC for 011.
- Minimum latency in cycles, MemPronta immediate:
  - R/110/ADDI: 4.
  - LW: 5.
  - SW, BEQZ, J: 4 / 3 / 3.
  - HALT: 2.

Decomposition:
- Package pkg_controle holds:
  - estado_t enum: OCIOSO, BUSCA, DECOD, EXEC, MEM, ESCRITA, PARADO, ERRO.
  - Opcode constants OP_R=000, OP_LW=001, OP_SW=010, OP_BEQZ=011, OP_ADDI=100, OP_J=101, OP_SUB=110, OP_HALT=111.
  - ULAOp constants and FontePC constants.
- One sub-module: contador_espera (EsperaCnt plus timeout compare, parameter ESPERA_MAX).
- Next-state logic and output decode stay in the top module.

Test Plan:
- Reset, Iniciar=1, opcode 000, MemPronta=1 always -> states BUSCA, DECOD, EXEC, ESCRITA. EscIR/EscPC in cycle 1, ULAOp=10 in cycle 3, EscReg=1 in cycle 4, NumInstr=1.
- LW with MemPronta delayed 3 cycles in MEM -> LerMem=1, IouD=1 held for 4 cycles, then ESCRITA with RegFonte=1, EscReg=1.
- BEQZ with Zero=1, then again with Zero=0 -> EscPC=1, FontePC=01 in EXEC only for Zero=1; both retire, NumInstr=2.
- MemPronta stuck 0 in BUSCA, ESPERA_MAX=15 -> ERRO entered after 16 BUSCA cycles, Erro=1, LerMem=0; Iniciar has no effect.
- Opcode 111 -> PARADO after DECOD, Parado=1, NumInstr+1, no strobes for 20 cycles.
- reset_n low mid-MEM of SW -> EscMem drops asynchronously, all outputs 0, NumInstr=0, state OCIOSO.
